// File: rtl/tone_synth.sv
// Square-wave note synthesizer; a note starts one cycle after acceptance, changes land on a toggle.
// One-entry pending register: note_ready drops while a note waits to be applied.
module tone_synth #(
  parameter int CLK_HZ  = 25000000,
  parameter int DIV_W   = 20,
  parameter int NUM_OCT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_sel,
  input  logic [1:0] octave,
  output logic       wave,
  output logic       busy,
  output logic [3:0] cur_note,
  output logic [1:0] cur_oct,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state, stateNext;
  logic [DIV_W-1:0] counter, counterNext;
  logic             waveNext;
  logic             pendFull, pendFullNext;
  logic [3:0]       pendNote, pendNoteNext, curNoteNext;
  logic [1:0]       pendOct, pendOctNext, curOctNext;
  logic             errNext;
  logic             accept, reqBad, toggle;
  logic [DIV_W-1:0] pendDiv, curDiv;

  // Half-period in clk cycles; every table entry folds to a constant at elaboration.
  function automatic logic [DIV_W-1:0] divOf(input logic [3:0] n, input logic [1:0] o);
    int unsigned d;
    case (n)
      4'd0:    d = CLK_HZ / (2 * 220);
      4'd1:    d = CLK_HZ / (2 * 233);
      4'd2:    d = CLK_HZ / (2 * 247);
      4'd3:    d = CLK_HZ / (2 * 262);
      4'd4:    d = CLK_HZ / (2 * 277);
      4'd5:    d = CLK_HZ / (2 * 294);
      4'd6:    d = CLK_HZ / (2 * 311);
      4'd7:    d = CLK_HZ / (2 * 330);
      4'd8:    d = CLK_HZ / (2 * 349);
      4'd9:    d = CLK_HZ / (2 * 370);
      4'd10:   d = CLK_HZ / (2 * 392);
      4'd11:   d = CLK_HZ / (2 * 415);
      default: d = 1;
    endcase
    d = d >> o;
    if (d == 0) d = 1;
    return DIV_W'(d);
  endfunction

  assign note_ready = !pendFull;
  assign busy       = (state != IDLE);
  assign accept     = note_valid && note_ready;
  assign reqBad     = (note_sel > 4'd11) || ({30'd0, octave} >= NUM_OCT);
  assign toggle     = (counter == '0);
  assign pendDiv    = divOf(pendNote, pendOct);
  assign curDiv     = divOf(cur_note, cur_oct);

  always_comb begin
    stateNext    = state;
    counterNext  = counter;
    waveNext     = wave;
    pendFullNext = pendFull;
    pendNoteNext = pendNote;
    pendOctNext  = pendOct;
    curNoteNext  = cur_note;
    curOctNext   = cur_oct;
    errNext      = 1'b0;

    // Acceptance only happens with pending empty, so it never collides with a consume below.
    if (accept) begin
      if (reqBad) begin
        errNext = 1'b1;
      end else begin
        pendFullNext = 1'b1;
        pendNoteNext = note_sel;
        pendOctNext  = octave;
      end
    end

    case (state)
      IDLE: begin
        waveNext = 1'b0;
        if (pendFull && enable) begin
          stateNext    = RUN;
          counterNext  = pendDiv - DIV_W'(1);
          curNoteNext  = pendNote;
          curOctNext   = pendOct;
          pendFullNext = 1'b0;
        end
      end
      RUN, STOP: begin
        if (state == RUN && !enable && !wave) begin
          stateNext   = IDLE;
          counterNext = '0;
        end else if (toggle) begin
          waveNext = !wave;
          if (enable) begin
            stateNext = RUN;
            if (pendFull) begin
              counterNext  = pendDiv - DIV_W'(1);
              curNoteNext  = pendNote;
              curOctNext   = pendOct;
              pendFullNext = 1'b0;
            end else begin
              counterNext = curDiv - DIV_W'(1);
            end
          end else if (wave) begin
            // Draining: this toggle brings wave low, so the tone ends here.
            stateNext   = IDLE;
            counterNext = '0;
          end else begin
            stateNext   = STOP;
            counterNext = curDiv - DIV_W'(1);
          end
        end else begin
          counterNext = counter - DIV_W'(1);
          stateNext   = enable ? RUN : STOP;
        end
      end
      default: begin
        stateNext   = IDLE;
        waveNext    = 1'b0;
        counterNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      wave     <= 1'b0;
      pendFull <= 1'b0;
      pendNote <= 4'd0;
      pendOct  <= 2'd0;
      cur_note <= 4'd0;
      cur_oct  <= 2'd0;
      err      <= 1'b0;
    end else begin
      state    <= stateNext;
      counter  <= counterNext;
      wave     <= waveNext;
      pendFull <= pendFullNext;
      pendNote <= pendNoteNext;
      pendOct  <= pendOctNext;
      cur_note <= curNoteNext;
      cur_oct  <= curOctNext;
      err      <= errNext;
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth at CLK_HZ=44000 (A/oct0 half-period = 100 cycles).
module tb_tone_synth;

  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_sel;
  logic [1:0] octave;
  logic       wave;
  logic       busy;
  logic [3:0] cur_note;
  logic [1:0] cur_oct;
  logic       err;

  int testCount = 0;
  int failCount = 0;

  tone_synth #(.CLK_HZ(44000), .DIV_W(20), .NUM_OCT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_sel   (note_sel),
    .octave     (octave),
    .wave       (wave),
    .busy       (busy),
    .cur_note   (cur_note),
    .cur_oct    (cur_oct),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until wave equals target; returns the number of ticks taken.
  task automatic waitWave(input string tag, input logic target, output int n);
    n = 0;
    while (wave !== target && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) checkVal({tag, "_timeout"}, n, 0);
  endtask

  task automatic sendNote(input logic [3:0] n, input logic [1:0] o);
    int w;
    w = 0;
    while (!note_ready && w < LIMIT) begin
      tick();
      w++;
    end
    if (w >= LIMIT) checkVal("send_timeout", w, 0);
    note_valid = 1'b1;
    note_sel   = n;
    octave     = o;
    tick();
    note_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic savedWave;

    rst_n      = 1'b0;
    enable     = 1'b0;
    note_valid = 1'b0;
    note_sel   = 4'd0;
    octave     = 2'd0;
    #2;
    checkVal("rst_wave",  wave,       0);
    checkVal("rst_busy",  busy,       0);
    checkVal("rst_ready", note_ready, 1);
    checkVal("rst_note",  cur_note,   0);
    checkVal("rst_oct",   cur_oct,    0);
    checkVal("rst_err",   err,        0);
    tick();
    tick();
    rst_n  = 1'b1;
    enable = 1'b1;

    // A/oct0: div 100
    sendNote(4'd0, 2'd0);
    checkVal("a_pend_ready", note_ready, 0);
    checkVal("a_pend_busy",  busy,       0);
    tick();
    checkVal("a_run_busy", busy, 1);
    checkVal("a_run_wave", wave, 0);
    waitWave("a_rise", 1'b1, n); checkVal("a_rise", n, 100);
    waitWave("a_fall", 1'b0, n); checkVal("a_high", n, 100);
    waitWave("a_rise2", 1'b1, n); checkVal("a_low", n, 100);

    // G/oct1 requested mid half-period: div 28, switch at the next toggle
    sendNote(4'd10, 2'd1);
    checkVal("g_before_note", cur_note, 0);
    waitWave("g_sw", 1'b0, n); checkVal("g_switch_half", n + 1, 100);
    checkVal("g_note", cur_note, 10);
    checkVal("g_oct",  cur_oct,  1);
    waitWave("g_h1", 1'b1, n); checkVal("g_half1", n, 28);
    waitWave("g_h2", 1'b0, n); checkVal("g_half2", n, 28);

    // Invalid note index dropped
    savedWave = wave;
    sendNote(4'd12, 2'd0);
    checkVal("bad_err",   err,        1);
    checkVal("bad_ready", note_ready, 1);
    tick();
    checkVal("bad_err_end", err,      0);
    checkVal("bad_note",    cur_note, 10);
    checkVal("bad_wave",    wave,     savedWave);

    // Back-to-back: B then C; C stalls until B lands on a toggle
    waitWave("bb_sync", 1'b1, n);
    sendNote(4'd2, 2'd0);
    note_valid = 1'b1;
    note_sel   = 4'd3;
    octave     = 2'd0;
    checkVal("bb_stall", note_ready, 0);
    n = 0;
    while (!note_ready && n < LIMIT) begin
      tick();
      n++;
    end
    checkVal("bb_stall_len", n, 27);
    checkVal("bb_b_note", cur_note, 2);
    tick();
    note_valid = 1'b0;
    checkVal("bb_c_pend", note_ready, 0);
    waitWave("bb_b", ~wave, n); checkVal("bb_b_half", n + 1, 89);
    checkVal("bb_c_note", cur_note, 3);
    waitWave("bb_c", ~wave, n); checkVal("bb_c_half", n, 83);

    // Enable dropped while wave is high: drain to the scheduled toggle
    waitWave("st_s0", 1'b0, n);
    waitWave("st_s1", 1'b1, n);
    repeat (10) tick();
    enable = 1'b0;
    waitWave("st_fall", 1'b0, n); checkVal("stop_fall", n, 73);
    checkVal("stop_busy", busy, 0);

    // Enable dropped while wave is low: idle on the next cycle
    enable = 1'b1;
    sendNote(4'd0, 2'd0);
    tick();
    checkVal("low_run_busy", busy, 1);
    enable = 1'b0;
    tick();
    checkVal("low_idle_busy", busy, 0);
    checkVal("low_idle_wave", wave, 0);

    // Pending note held while disabled
    sendNote(4'd5, 2'd0);
    repeat (3) tick();
    checkVal("hold_busy",  busy,       0);
    checkVal("hold_ready", note_ready, 0);
    enable = 1'b1;
    tick();
    checkVal("hold_go_busy", busy,     1);
    checkVal("hold_go_note", cur_note, 5);

    // Reset mid-tone, then a fresh A/oct0
    waitWave("rs_sync", 1'b1, n);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checkVal("mid_rst_wave",  wave,       0);
    checkVal("mid_rst_busy",  busy,       0);
    checkVal("mid_rst_ready", note_ready, 1);
    checkVal("mid_rst_note",  cur_note,   0);
    tick();
    rst_n = 1'b1;
    sendNote(4'd0, 2'd0);
    tick();
    checkVal("re_busy", busy, 1);
    waitWave("re_rise", 1'b1, n); checkVal("re_rise", n, 100);
    waitWave("re_fall", 1'b0, n); checkVal("re_high", n, 100);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 25000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter DIV_W, default 20, meaning width of the half-period divider and counter.
REQ-003 The block SHALL have parameter NUM_OCT, default 4, meaning the number of selectable octaves (octave index 0..NUM_OCT-1).
REQ-004 The block SHALL have port clk, input, width 1, meaning the single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, width 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, width 1, meaning tone output permitted.
REQ-007 The block SHALL have port note_valid, input, width 1, meaning a note request is present.
REQ-008 The block SHALL have port note_ready, output, width 1, meaning a note request can be accepted.
REQ-009 The block SHALL have port note_sel, input, width 4, meaning chromatic note index 0..11 (0=A ... 11=G#).
REQ-010 The block SHALL have port octave, input, width 2, meaning octave shift index.
REQ-011 The block SHALL have port wave, output, width 1, meaning the square-wave tone.
REQ-012 The block SHALL have port busy, output, width 1, meaning the state is not IDLE.
REQ-013 The block SHALL have port cur_note, output, width 4, meaning the note currently sounding.
REQ-014 The block SHALL have port cur_oct, output, width 2, meaning the octave currently sounding.
REQ-015 The block SHALL have port err, output, width 1, meaning a one-cycle pulse when an invalid request is dropped.

Function
REQ-016 Base table (Hz), index 0..11: 220,233,247,262,277,294,311,330,349,370,392,415; each entry is an elaboration-time constant.
REQ-017 Divider div SHALL be floor(CLK_HZ/(2*freq)) >> octave, clamped to a minimum of 1, truncated to DIV_W bits.
REQ-018 A request SHALL be accepted on a cycle where note_valid and note_ready are both 1.
REQ-019 An accepted request with note_sel>11 or octave>=NUM_OCT SHALL be dropped, with err=1 on the following cycle and no state change.
REQ-020 A valid accepted request SHALL be written to a one-entry pending register; note_ready=0 while pending is full.
REQ-021 The states SHALL be IDLE, RUN and STOP.
REQ-022 IDLE to RUN SHALL occur when pending is full and enable=1: counter=div-1, wave=0, cur_note/cur_oct loaded, pending cleared.
REQ-023 In RUN, the counter SHALL decrement each cycle; at counter==0 (a toggle), wave inverts and the counter reloads to div-1, giving half-period = div cycles and period = 2*div.
REQ-024 If pending is full at a toggle in RUN, the reload SHALL use the pending note's div, cur_note/cur_oct SHALL update, and pending SHALL clear, so there is no partial half-period.
REQ-025 A request accepted on a toggle cycle SHALL be applied at the next toggle, not the current one.
REQ-026 RUN SHALL go to STOP when enable=0; if wave=0 at that moment, the state SHALL go directly to IDLE.
REQ-027 In STOP, counting SHALL continue, and the toggle that drives wave to 0 SHALL end in IDLE with wave held at 0.
REQ-028 If enable returns to 1 during STOP, the state SHALL return to RUN without disturbing the counter or wave.
REQ-029 Requests SHALL be accepted in any state when pending is empty; with enable=0 a pending note SHALL be held until enable=1.
REQ-030 busy SHALL be 1 in RUN and STOP, and 0 in IDLE.

Reset
REQ-031 When rst_n=0, immediately: state=IDLE, wave=0, counter=0, pending empty, note_ready=1, busy=0, cur_note=0, cur_oct=0, err=0.
REQ-032 Reset asserted mid-tone SHALL abort the tone with no drain; after release, the next accepted note SHALL start fresh per REQ-022.

Verification
REQ-033 Test: CLK_HZ=44000, enable=1, request A/oct0 -> div=100; wave rises 100 cycles after RUN entry; period 200.
REQ-034 Test: during A/oct0, request G/oct1 -> div=28; change occurs exactly at the next toggle; no half-period other than 100 or 28.
REQ-035 Test: request note_sel=12 -> err pulse of 1 cycle; note_ready stays 1; wave and cur_note unchanged.
REQ-036 Test: deassert enable while wave=1 -> wave falls at the scheduled toggle, then IDLE and busy=0; with wave=0 -> IDLE next cycle.
REQ-037 Test: two back-to-back requests during RUN -> second stalls (note_ready=0) until first applied at a toggle.
REQ-038 Test: assert rst_n=0 mid-period -> wave=0 and busy=0 immediately; new A request after release reproduces REQ-033 timing.
